l1_tag_assoc_unit: RTL and testbench
====================================

Name: l1_tag_assoc_unit

Overview:
- Parametrised N-way set-associative L1 tag unit for the SIMD memory system. It is the successor to the direct-mapped L1 tag lookup.
- Accepts one coalesced line lookup per cycle and returns hit/way/delay one cycle later.
- Allocates lines on fill with invalid-first, then per-set round-robin replacement, and reports evicted lines.
- Provides a sequential flush (invalidate-all) engine. Sits between the coalescer and the L2 request path.

Parameters:
ADDR_W, 32, byte address width
LINE_LOG, 5, log2 bytes per memory line
SETS_LOG, 7, log2 number of sets
WAYS, 4, associativity (power of 2, >=2)
HIT_DELAY, 1, value driven on resp_delay on hit
DELAY_W, 10, width of resp_delay
Derived: TAG_W = ADDR_W-SETS_LOG-LINE_LOG; WAY_LOG = log2(WAYS)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
stall  in  1  global pipeline stall; freezes all state and outputs
lookup_valid  in  1  lookup request this cycle
lookup_addr  in  ADDR_W  coalesced byte address
fill_valid  in  1  install line (L2/DRAM return)
fill_addr  in  ADDR_W  byte address of filled line
flush_req  in  1  start invalidate-all; level sampled when idle
resp_valid  out  1  lookup result valid
resp_hit  out  1  lookup hit
resp_way  out  WAY_LOG  hitting way (0 on miss)
resp_delay  out  DELAY_W  HIT_DELAY on hit, 0 on miss
evict_valid  out  1  fill replaced a valid line
evict_addr  out  ADDR_W  line address of evicted line, low LINE_LOG bits 0
flush_busy  out  1  flush sweep in progress

Behaviour:
- Address split: index = addr[SETS_LOG+LINE_LOG-1:LINE_LOG]; tag = addr[ADDR_W-1:SETS_LOG+LINE_LOG].
- Storage per set: WAYS x {valid, tag}, plus a WAY_LOG round-robin pointer rr.
- Reset: all valid bits=0, all rr=0, FSM=IDLE. All outputs 0 from the first cycle after reset is sampled high. A reset during a flush aborts it; the array is still fully invalidated.
- stall=1: no state changes, outputs hold, inputs ignored (including flush_req).
- Lookup latency is 1 cycle. resp_* are registered. resp_valid = lookup_valid registered. resp_hit=1 iff some way of the set has valid=1 and a matching tag. At most one way matches (no duplicates are ever installed).
- Fill: takes effect at the clock edge. Way selection:
  - If the tag is already present, rewrite that way; no eviction, rr unchanged.
  - Otherwise, if an invalid way exists, use the lowest-index invalid way; rr += 1 mod WAYS.
  - Otherwise use way rr; rr += 1 mod WAYS; evict_valid=1 and evict_addr={old tag, index, 0}, registered with 1-cycle latency.
- Simultaneous lookup and fill: the lookup sees pre-fill state (no bypass). This holds for the same set and for the same line.
- FSM IDLE -> FLUSH when flush_req=1 in IDLE. FLUSH clears the valid bits of set cnt, one set per cycle, cnt = 0..2^SETS_LOG-1. After the last set -> IDLE. Total 2^SETS_LOG cycles with flush_busy=1. rr is also cleared per set.
- During FLUSH: lookups return resp_valid=1, resp_hit=0; fills are dropped; flush_req is ignored.
- evict_valid is a 1-cycle pulse, 0 otherwise. resp_way=0 and resp_delay=0 when resp_hit=0.

Decomposition:
- Shared package l1_cache_pkg holds:
  - address-split helper functions (index/tag extraction);
  - delay constants (L1/L2/DRAM delay);
  - the {valid, tag} way-entry typedef.
- One sub-module, l1_tag_way_match: given the set's WAYS entries and a tag, outputs hit, one-hot match, encoded way, lowest invalid way, any_invalid. It is instantiated twice, for the lookup and fill ports.

Test Plan:
- Reset, then lookup 0x0000_1000 -> next cycle resp_valid=1, resp_hit=0, resp_delay=0.
- Fill 0x1000, then lookup 0x1004 -> resp_hit=1, resp_way=0, resp_delay=1.
- Fill 0x0000, 0x1000, 0x2000, 0x3000 (all set 0) -> ways 0..3, no evict. Fill 0x4000 -> evict_valid=1, evict_addr=0x0000. Lookup 0x0000 misses; lookup 0x4000 hits way 0.
- Fill 0x2000 twice -> no eviction, rr unchanged, single matching way.
- Same-cycle lookup+fill of 0x5000 -> resp_hit=0. Lookup of 0x5000 on the next cycle -> resp_hit=1.
- Fill 0x1000, pulse flush_req -> flush_busy=1 for 128 cycles; lookups and fills during the sweep miss/drop. Afterwards lookup 0x1000 -> miss.
- Extra: stall held 3 cycles mid-flush -> the flush completes 3 cycles late and outputs are frozen during the stall.

Source files
------------

// File: rtl/l1_cache_pkg.sv
// Shared L1 constants, the {valid, tag} way entry, and address-split helpers.
package l1_cache_pkg;

    localparam int L1_ADDR_W   = 32;
    localparam int L1_LINE_LOG = 5;
    localparam int L1_SETS_LOG = 7;
    localparam int L1_TAG_W    = L1_ADDR_W - L1_SETS_LOG - L1_LINE_LOG;

    localparam int L1_DELAY   = 1;
    localparam int L2_DELAY   = 20;
    localparam int DRAM_DELAY = 200;

    typedef struct packed {
        logic                valid;
        logic [L1_TAG_W-1:0] tag;
    } way_entry_t;

    function automatic logic [L1_SETS_LOG-1:0] addr_index(input logic [L1_ADDR_W-1:0] addr);
        return L1_SETS_LOG'(addr >> L1_LINE_LOG);
    endfunction

    function automatic logic [L1_TAG_W-1:0] addr_tag(input logic [L1_ADDR_W-1:0] addr);
        return L1_TAG_W'(addr >> (L1_SETS_LOG + L1_LINE_LOG));
    endfunction

endpackage

// File: rtl/l1_tag_way_match.sv
// Combinational tag compare across one set: hit, one-hot match, encoded way,
// and the lowest-index invalid way for allocation.
module l1_tag_way_match
    import l1_cache_pkg::*;
#(
    parameter int WAYS    = 4,
    parameter int WAY_LOG = $clog2(WAYS)
) (
    input  way_entry_t [WAYS-1:0]    entries_i,
    input  logic [L1_TAG_W-1:0]      tag_i,
    output logic                     hit_o,
    output logic [WAYS-1:0]          match_oh_o,
    output logic [WAY_LOG-1:0]       way_o,
    output logic [WAY_LOG-1:0]       inv_way_o,
    output logic                     any_inv_o
);

    always_comb begin
        match_oh_o = '0;
        way_o      = '0;
        inv_way_o  = '0;
        any_inv_o  = 1'b0;
        // Walking downward leaves the lowest-index invalid way selected.
        for (int w = WAYS - 1; w >= 0; w--) begin
            match_oh_o[w] = entries_i[w].valid && (entries_i[w].tag == tag_i);
            if (match_oh_o[w]) way_o = WAY_LOG'(w);
            if (!entries_i[w].valid) begin
                inv_way_o = WAY_LOG'(w);
                any_inv_o = 1'b1;
            end
        end
        hit_o = |match_oh_o;
    end

endmodule

// File: rtl/l1_tag_assoc_unit.sv
// N-way set-associative L1 tag array: 1-cycle lookup, fill with invalid-first then
// round-robin replacement, eviction report, and a one-set-per-cycle flush sweep.
module l1_tag_assoc_unit
    import l1_cache_pkg::*;
#(
    parameter int ADDR_W    = L1_ADDR_W,
    parameter int LINE_LOG  = L1_LINE_LOG,
    parameter int SETS_LOG  = L1_SETS_LOG,
    parameter int WAYS      = 4,
    parameter int HIT_DELAY = L1_DELAY,
    parameter int DELAY_W   = 10
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        stall,
    input  logic                        lookup_valid,
    input  logic [ADDR_W-1:0]           lookup_addr,
    input  logic                        fill_valid,
    input  logic [ADDR_W-1:0]           fill_addr,
    input  logic                        flush_req,
    output logic                        resp_valid,
    output logic                        resp_hit,
    output logic [$clog2(WAYS)-1:0]     resp_way,
    output logic [DELAY_W-1:0]          resp_delay,
    output logic                        evict_valid,
    output logic [ADDR_W-1:0]           evict_addr,
    output logic                        flush_busy
);

    localparam int WAY_LOG = $clog2(WAYS);
    localparam int SETS    = 1 << SETS_LOG;

    typedef enum logic {IDLE, FLUSH} state_t;

    // Address widths and the entry tag width come from the package; overrides must agree.
    state_t                        state_q;
    logic [SETS_LOG-1:0]           cnt_q;
    logic [SETS-1:0][WAYS-1:0]     valid_q;
    logic [SETS-1:0][WAY_LOG-1:0]  rr_q;
    logic [L1_TAG_W-1:0]           tag_q [SETS][WAYS];

    logic                          resp_valid_q, resp_hit_q, evict_valid_q, flush_busy_q;
    logic [WAY_LOG-1:0]            resp_way_q;
    logic [DELAY_W-1:0]            resp_delay_q;
    logic [ADDR_W-1:0]             evict_addr_q;

    logic [SETS_LOG-1:0]           lk_idx, fl_idx;
    logic [L1_TAG_W-1:0]           lk_tag, fl_tag;
    way_entry_t [WAYS-1:0]         lk_ent, fl_ent;
    logic                          lk_hit, fl_hit, lk_any_inv, fl_any_inv;
    logic [WAYS-1:0]               lk_oh, fl_oh;
    logic [WAY_LOG-1:0]            lk_way, fl_way, lk_inv_way, fl_inv_way;
    logic [WAY_LOG-1:0]            fl_sel_d;
    logic                          fl_rr_adv_d, fl_evict_d, lk_unused;

    assign lk_idx = addr_index(lookup_addr);
    assign lk_tag = addr_tag(lookup_addr);
    assign fl_idx = addr_index(fill_addr);
    assign fl_tag = addr_tag(fill_addr);

    always_comb begin
        lk_ent = '0;
        fl_ent = '0;
        for (int w = 0; w < WAYS; w++) begin
            lk_ent[w].valid = valid_q[lk_idx][w];
            lk_ent[w].tag   = tag_q[lk_idx][w];
            fl_ent[w].valid = valid_q[fl_idx][w];
            fl_ent[w].tag   = tag_q[fl_idx][w];
        end
    end

    l1_tag_way_match #(.WAYS(WAYS), .WAY_LOG(WAY_LOG)) u_lk_match (
        .entries_i(lk_ent), .tag_i(lk_tag), .hit_o(lk_hit), .match_oh_o(lk_oh),
        .way_o(lk_way), .inv_way_o(lk_inv_way), .any_inv_o(lk_any_inv)
    );

    l1_tag_way_match #(.WAYS(WAYS), .WAY_LOG(WAY_LOG)) u_fl_match (
        .entries_i(fl_ent), .tag_i(fl_tag), .hit_o(fl_hit), .match_oh_o(fl_oh),
        .way_o(fl_way), .inv_way_o(fl_inv_way), .any_inv_o(fl_any_inv)
    );

    assign lk_unused = ^{lk_inv_way, lk_any_inv};

    always_comb begin
        fl_sel_d    = fl_way;
        fl_rr_adv_d = 1'b0;
        fl_evict_d  = 1'b0;
        if (!fl_hit) begin
            fl_rr_adv_d = 1'b1;
            if (fl_any_inv) begin
                fl_sel_d = fl_inv_way;
            end else begin
                fl_sel_d   = rr_q[fl_idx];
                fl_evict_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            valid_q       <= '0;
            rr_q          <= '0;
            resp_valid_q  <= 1'b0;
            resp_hit_q    <= 1'b0;
            resp_way_q    <= '0;
            resp_delay_q  <= '0;
            evict_valid_q <= 1'b0;
            evict_addr_q  <= '0;
            flush_busy_q  <= 1'b0;
        end else if (!stall) begin
            resp_valid_q  <= lookup_valid;
            resp_hit_q    <= lookup_valid && lk_hit && (state_q == IDLE);
            resp_way_q    <= (lookup_valid && lk_hit && (state_q == IDLE)) ? lk_way : '0;
            resp_delay_q  <= (lookup_valid && lk_hit && (state_q == IDLE)) ? DELAY_W'(HIT_DELAY) : '0;
            evict_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (fill_valid) begin
                        valid_q[fl_idx][fl_sel_d] <= 1'b1;
                        if (fl_rr_adv_d) rr_q[fl_idx] <= rr_q[fl_idx] + 1'b1;
                        if (fl_evict_d) begin
                            evict_valid_q <= 1'b1;
                            evict_addr_q  <= {tag_q[fl_idx][fl_sel_d], fl_idx, {LINE_LOG{1'b0}}};
                        end
                    end
                    if (flush_req) begin
                        state_q      <= FLUSH;
                        cnt_q        <= '0;
                        flush_busy_q <= 1'b1;
                    end
                end
                FLUSH: begin
                    valid_q[cnt_q] <= '0;
                    rr_q[cnt_q]    <= '0;
                    cnt_q          <= cnt_q + 1'b1;
                    if (cnt_q == SETS_LOG'(SETS - 1)) begin
                        state_q      <= IDLE;
                        flush_busy_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Tags need no reset: a way's tag is only observed while its valid bit is set.
    always_ff @(posedge clk) begin
        if (!reset && !stall && (state_q == IDLE) && fill_valid)
            tag_q[fl_idx][fl_sel_d] <= fl_tag;
    end

    assert property (@(posedge clk) disable iff (reset) $onehot0(lk_oh) && $onehot0(fl_oh));

    assign resp_valid  = resp_valid_q;
    assign resp_hit    = resp_hit_q;
    assign resp_way    = resp_way_q;
    assign resp_delay  = resp_delay_q;
    assign evict_valid = evict_valid_q;
    assign evict_addr  = evict_addr_q;
    assign flush_busy  = flush_busy_q;

endmodule

// File: tb/tb_l1_tag_assoc_unit.sv
// Directed bench for l1_tag_assoc_unit with hand-computed expectations.
module tb_l1_tag_assoc_unit;

    logic        clk = 1'b0;
    logic        reset, stall, lookup_valid, fill_valid, flush_req;
    logic [31:0] lookup_addr, fill_addr;
    logic        resp_valid, resp_hit, evict_valid, flush_busy;
    logic [1:0]  resp_way;
    logic [9:0]  resp_delay;
    logic [31:0] evict_addr;
    int          checks = 0;
    int          passed = 0;
    int          cycles;

    always #5 clk = ~clk;

    l1_tag_assoc_unit dut (
        .clk(clk), .reset(reset), .stall(stall),
        .lookup_valid(lookup_valid), .lookup_addr(lookup_addr),
        .fill_valid(fill_valid), .fill_addr(fill_addr), .flush_req(flush_req),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
        .resp_delay(resp_delay), .evict_valid(evict_valid), .evict_addr(evict_addr),
        .flush_busy(flush_busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_lookup(input logic [31:0] a);
        lookup_valid = 1'b1; lookup_addr = a;
        tick;
        lookup_valid = 1'b0;
    endtask

    task automatic do_fill(input logic [31:0] a);
        fill_valid = 1'b1; fill_addr = a;
        tick;
        fill_valid = 1'b0;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; lookup_valid = 1'b1; lookup_addr = 32'h1000;
        fill_valid = 1'b1; fill_addr = 32'h1000; flush_req = 1'b1;
        tick; tick;
        reset = 1'b0; lookup_valid = 1'b0; fill_valid = 1'b0; flush_req = 1'b0;
        checks++;
        if ({resp_valid, resp_hit, resp_way, resp_delay} !== 14'd0)
            $display("FAIL reset_resp: got %h want 0", {resp_valid, resp_hit, resp_way, resp_delay});
        else passed++;
        checks++;
        if ({evict_valid, evict_addr} !== 33'd0)
            $display("FAIL reset_evict: got %h want 0", {evict_valid, evict_addr});
        else passed++;
        checks++;
        if (flush_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", flush_busy);
        else passed++;
    endtask

    task automatic test_miss;
        do_lookup(32'h0000_1000);
        checks++;
        if ({resp_valid, resp_hit, resp_delay} !== {1'b1, 1'b0, 10'd0})
            $display("FAIL cold_miss: got v=%b h=%b d=%0d want v=1 h=0 d=0", resp_valid, resp_hit, resp_delay);
        else passed++;
    endtask

    task automatic test_fill_hit;
        do_fill(32'h1000);
        checks++;
        if (evict_valid !== 1'b0) $display("FAIL first_fill_evict: got %b want 0", evict_valid);
        else passed++;
        do_lookup(32'h1004);
        checks++;
        if ({resp_valid, resp_hit, resp_way, resp_delay} !== {1'b1, 1'b1, 2'd0, 10'd1})
            $display("FAIL fill_hit: got v=%b h=%b w=%0d d=%0d want 1 1 0 1", resp_valid, resp_hit, resp_way, resp_delay);
        else passed++;
    endtask

    task automatic test_evict;
        for (int k = 0; k < 4; k++) begin
            do_fill(32'h1000 * k);
            checks++;
            if (evict_valid !== 1'b0) $display("FAIL fill_free_way%0d: evict got %b want 0", k, evict_valid);
            else passed++;
        end
        do_fill(32'h4000);
        checks++;
        if ({evict_valid, evict_addr} !== {1'b1, 32'h0000_0000})
            $display("FAIL evict_rr0: got v=%b a=%h want v=1 a=00000000", evict_valid, evict_addr);
        else passed++;
        tick;
        checks++;
        if (evict_valid !== 1'b0) $display("FAIL evict_pulse: got %b want 0", evict_valid);
        else passed++;
        do_lookup(32'h0000);
        checks++;
        if (resp_hit !== 1'b0) $display("FAIL evicted_miss: got %b want 0", resp_hit);
        else passed++;
        do_lookup(32'h4000);
        checks++;
        if ({resp_hit, resp_way} !== 3'b100) $display("FAIL new_way0: got h=%b w=%0d want h=1 w=0", resp_hit, resp_way);
        else passed++;
        do_lookup(32'h3000);
        checks++;
        if ({resp_hit, resp_way} !== 3'b111) $display("FAIL way3: got h=%b w=%0d want h=1 w=3", resp_hit, resp_way);
        else passed++;
        for (int k = 0; k < 4; k++) do_fill(32'h0060 + 32'h1000 * k);
        do_fill(32'h4060);
        checks++;
        if ({evict_valid, evict_addr} !== {1'b1, 32'h0000_0060})
            $display("FAIL evict_set3: got v=%b a=%h want v=1 a=00000060", evict_valid, evict_addr);
        else passed++;
    endtask

    task automatic test_refill;
        for (int k = 0; k < 2; k++) begin
            do_fill(32'h2000);
            checks++;
            if (evict_valid !== 1'b0) $display("FAIL refill%0d_evict: got %b want 0", k, evict_valid);
            else passed++;
        end
        do_lookup(32'h2000);
        checks++;
        if ({resp_hit, resp_way} !== 3'b110) $display("FAIL refill_way: got h=%b w=%0d want h=1 w=2", resp_hit, resp_way);
        else passed++;
    endtask

    task automatic test_same_cycle;
        lookup_valid = 1'b1; lookup_addr = 32'h5000;
        fill_valid = 1'b1; fill_addr = 32'h5000;
        tick;
        lookup_valid = 1'b0; fill_valid = 1'b0;
        checks++;
        if ({resp_valid, resp_hit} !== 2'b10) $display("FAIL same_cycle_nobypass: got v=%b h=%b want v=1 h=0", resp_valid, resp_hit);
        else passed++;
        // rr stayed at 1 through the duplicate fills, so way 1 (0x1000) is the victim.
        checks++;
        if ({evict_valid, evict_addr} !== {1'b1, 32'h0000_1000})
            $display("FAIL same_cycle_victim: got v=%b a=%h want v=1 a=00001000", evict_valid, evict_addr);
        else passed++;
        do_lookup(32'h5000);
        checks++;
        if ({resp_hit, resp_way} !== 3'b101) $display("FAIL next_cycle_hit: got h=%b w=%0d want h=1 w=1", resp_hit, resp_way);
        else passed++;
    endtask

    task automatic test_flush;
        do_fill(32'h1000);
        do_lookup(32'h1000);
        checks++;
        if (resp_hit !== 1'b1) $display("FAIL preflush_hit: got %b want 1", resp_hit);
        else passed++;
        flush_req = 1'b1;
        tick;
        flush_req = 1'b0;
        checks++;
        if (flush_busy !== 1'b1) $display("FAIL flush_start: got %b want 1", flush_busy);
        else passed++;
        cycles = 1;
        for (int k = 0; k < 300; k++) begin
            if (flush_busy !== 1'b1) break;
            lookup_valid = (cycles == 1); lookup_addr = 32'h1000;
            fill_valid = (cycles == 100); fill_addr = 32'h7000;
            flush_req = (cycles == 50);
            tick;
            if (lookup_valid) begin
                checks++;
                if ({resp_valid, resp_hit} !== 2'b10) $display("FAIL flush_lookup: got v=%b h=%b want v=1 h=0", resp_valid, resp_hit);
                else passed++;
            end
            if (flush_busy) cycles++;
        end
        lookup_valid = 1'b0; fill_valid = 1'b0; flush_req = 1'b0;
        checks++;
        if (cycles !== 128) $display("FAIL flush_len: got %0d cycles want 128", cycles);
        else passed++;
        do_lookup(32'h1000);
        checks++;
        if ({resp_valid, resp_hit} !== 2'b10) $display("FAIL postflush_miss: got v=%b h=%b want v=1 h=0", resp_valid, resp_hit);
        else passed++;
        do_lookup(32'h7000);
        checks++;
        if (resp_hit !== 1'b0) $display("FAIL flush_fill_dropped: got %b want 0", resp_hit);
        else passed++;
        for (int k = 0; k < 4; k++) do_fill(32'h1000 * k);
        do_fill(32'h4000);
        checks++;
        if ({evict_valid, evict_addr} !== {1'b1, 32'h0000_0000})
            $display("FAIL flush_rr_clear: got v=%b a=%h want v=1 a=00000000", evict_valid, evict_addr);
        else passed++;
    endtask

    task automatic test_stall_idle;
        do_fill(32'h6000);
        checks++;
        if ({evict_valid, evict_addr} !== {1'b1, 32'h0000_1000})
            $display("FAIL stall_pre_evict: got v=%b a=%h want v=1 a=00001000", evict_valid, evict_addr);
        else passed++;
        stall = 1'b1; lookup_valid = 1'b1; lookup_addr = 32'h6000;
        fill_valid = 1'b1; fill_addr = 32'h7000; flush_req = 1'b1;
        tick;
        stall = 1'b0; lookup_valid = 1'b0; fill_valid = 1'b0; flush_req = 1'b0;
        checks++;
        if ({evict_valid, evict_addr, resp_valid, flush_busy} !== {1'b1, 32'h0000_1000, 1'b0, 1'b0})
            $display("FAIL stall_freeze: got ev=%b ea=%h rv=%b fb=%b want 1 00001000 0 0",
                     evict_valid, evict_addr, resp_valid, flush_busy);
        else passed++;
        tick;
        checks++;
        if ({evict_valid, flush_busy} !== 2'b00) $display("FAIL stall_release: got ev=%b fb=%b want 0 0", evict_valid, flush_busy);
        else passed++;
        do_lookup(32'h7000);
        checks++;
        if (resp_hit !== 1'b0) $display("FAIL stalled_fill_ignored: got %b want 0", resp_hit);
        else passed++;
    endtask

    task automatic test_stall_flush;
        flush_req = 1'b1;
        tick;
        flush_req = 1'b0;
        cycles = 1;
        for (int k = 0; k < 300; k++) begin
            if (flush_busy !== 1'b1) break;
            lookup_valid = (cycles == 10); lookup_addr = 32'h6000;
            stall = (cycles >= 11 && cycles <= 13);
            tick;
            if (stall) begin
                checks++;
                if ({resp_valid, resp_hit, flush_busy} !== 3'b101)
                    $display("FAIL flush_stall_hold: got v=%b h=%b fb=%b want 1 0 1", resp_valid, resp_hit, flush_busy);
                else passed++;
            end
            if (flush_busy) cycles++;
        end
        stall = 1'b0; lookup_valid = 1'b0;
        checks++;
        if (cycles !== 131) $display("FAIL flush_stall_len: got %0d cycles want 131", cycles);
        else passed++;
    endtask

    task automatic test_reset_abort;
        do_fill(32'h0C80);
        do_lookup(32'h0C80);
        checks++;
        if (resp_hit !== 1'b1) $display("FAIL set100_hit: got %b want 1", resp_hit);
        else passed++;
        flush_req = 1'b1;
        tick;
        flush_req = 1'b0;
        for (int k = 0; k < 5; k++) tick;
        do_reset;
        checks++;
        if (flush_busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", flush_busy);
        else passed++;
        do_lookup(32'h0C80);
        checks++;
        if ({resp_valid, resp_hit, flush_busy} !== 3'b100)
            $display("FAIL abort_invalid: got v=%b h=%b fb=%b want 1 0 0", resp_valid, resp_hit, flush_busy);
        else passed++;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; lookup_valid = 1'b0; fill_valid = 1'b0; flush_req = 1'b0;
        lookup_addr = '0; fill_addr = '0;
        test_reset;
        test_miss;
        test_fill_hit;
        do_reset;
        test_evict;
        test_refill;
        test_same_cycle;
        test_flush;
        test_stall_idle;
        test_stall_flush;
        test_reset_abort;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, checks);
        $fatal(1);
    end

endmodule
